// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, twiddle constant, FSM states and butterfly addressing for the 8-point FFT blocks.
package fft_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int TW_FRAC_DEF = 14;
  localparam int GUARD_W_DEF = 4;
  localparam int TW_C = 11585;
  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] t;
  } bfly_sel_t;
  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction
  function automatic bfly_sel_t bfly_sel(input logic [1:0] s, input logic [1:0] j);
    bfly_sel_t r;
    int h, lo, a;
    h = 1 << s;
    lo = int'(j) % h;
    a = (int'(j) >> s) * 2 * h + lo;
    r.a = 3'(a);
    r.b = 3'(a + h);
    r.t = 2'(lo * (4 >> s));
    return r;
  endfunction
endpackage

// File: rtl/fft_bfly_r2.sv
// fft_bfly_r2: combinational radix-2 butterfly y0 = a + W*b, y1 = a - W*b, W = exp(+/-j*2*pi*t/8).
module fft_bfly_r2 import fft_pkg::*; #(
  parameter int IW = 36,
  parameter int TW_FRAC = 14,
  parameter int TW_CONST = TW_C
) (
  input  logic                 inv,
  input  logic [1:0]           t,
  input  logic signed [IW-1:0] a_re,
  input  logic signed [IW-1:0] a_im,
  input  logic signed [IW-1:0] b_re,
  input  logic signed [IW-1:0] b_im,
  output logic signed [IW-1:0] y0_re,
  output logic signed [IW-1:0] y0_im,
  output logic signed [IW-1:0] y1_re,
  output logic signed [IW-1:0] y1_im
);
  localparam int PW = IW + TW_FRAC + 2;
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (TW_FRAC - 1));
  logic signed [PW-1:0] kr, ki;
  logic signed [IW-1:0] rr, ii, ri, ir, w_re, w_im;
  function automatic logic signed [IW-1:0] rnd(input logic signed [PW-1:0] p);
    return IW'((p + HALF) >>> TW_FRAC);
  endfunction
  // odd twiddles: real part +/-C by t, imag part sign by direction
  assign kr = t[1] ? -PW'(TW_CONST) : PW'(TW_CONST);
  assign ki = inv ? PW'(TW_CONST) : -PW'(TW_CONST);
  assign rr = rnd(PW'(b_re) * kr);
  assign ii = rnd(PW'(b_im) * ki);
  assign ri = rnd(PW'(b_im) * kr);
  assign ir = rnd(PW'(b_re) * ki);
  always_comb begin
    w_re = t[0] ? rr - ii : (t[1] ? (inv ? -b_im : b_im) : b_re);
    w_im = t[0] ? ri + ir : (t[1] ? (inv ? b_re : -b_re) : b_im);
  end
  assign y0_re = a_re + w_re;
  assign y0_im = a_im + w_im;
  assign y1_re = a_re - w_re;
  assign y1_im = a_im - w_im;
endmodule

// File: rtl/ifft8_seq.sv
// ifft8_seq: sequential 8-point inverse FFT, one in-place butterfly per cycle, outputs scaled by 1/8.
module ifft8_seq import fft_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_FRAC = TW_FRAC_DEF,
  parameter int GUARD_W = GUARD_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [2:0]               out_idx,
  output logic                     out_last,
  output logic                     busy
);
  localparam int IW = DATA_W + GUARD_W;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic signed [IW-1:0] re_q [8], im_q [8], re_d [8], im_d [8];
  logic signed [IW-1:0] y0_re, y0_im, y1_re, y1_im;
  bfly_sel_t sel;
  assign sel = bfly_sel(cnt_q[3:2], cnt_q[1:0]);
  fft_bfly_r2 #(.IW(IW), .TW_FRAC(TW_FRAC), .TW_CONST(TW_C)) u_bfly (
    .inv(1'b1), .t(sel.t),
    .a_re(re_q[sel.a]), .a_im(im_q[sel.a]), .b_re(re_q[sel.b]), .b_im(im_q[sel.b]),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im)
  );
  assign in_ready = !rst && state_q == LOAD;
  assign busy = state_q != LOAD;
  assign out_valid = state_q == OUT;
  assign out_idx = cnt_q[2:0];
  assign out_last = out_valid && cnt_q[2:0] == 3'd7;
  assign out_re = DATA_W'(re_q[out_idx] >>> 3);
  assign out_im = DATA_W'(im_q[out_idx] >>> 3);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    re_d = re_q;
    im_d = im_q;
    case (state_q)
      LOAD: if (in_valid && in_ready) begin
        re_d[bitrev3(cnt_q[2:0])] = IW'(in_re);
        im_d[bitrev3(cnt_q[2:0])] = IW'(in_im);
        cnt_d = cnt_q[2:0] == 3'd7 ? '0 : cnt_q + 4'd1;
        state_d = cnt_q[2:0] == 3'd7 ? COMPUTE : LOAD;
      end
      COMPUTE: begin
        re_d[sel.a] = y0_re;
        im_d[sel.a] = y0_im;
        re_d[sel.b] = y1_re;
        im_d[sel.b] = y1_im;
        cnt_d = cnt_q == 4'd11 ? '0 : cnt_q + 4'd1;
        state_d = cnt_q == 4'd11 ? OUT : COMPUTE;
      end
      OUT: if (out_ready) begin
        cnt_d = cnt_q[2:0] == 3'd7 ? '0 : cnt_q + 4'd1;
        state_d = cnt_q[2:0] == 3'd7 ? LOAD : OUT;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q <= '0;
      re_q <= '{default: '0};
      im_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      re_q <= re_d;
      im_q <= im_d;
    end
  end
endmodule

// File: tb/tb_ifft8_seq.sv
// tb_ifft8_seq: scoreboard bench for ifft8_seq with directed spectra, random frames and a reference model.
module tb_ifft8_seq;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [31:0] in_re, in_im, out_re, out_im;
  logic [2:0] out_idx;
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [2:0]  idx;
    logic        last;
  } beat_t;
  beat_t sb [$];
  int errors = 0, checks = 0, cyc = 0, last_hs = 0, first_v = 0;
  bit prev_v = 0, bp_rand = 0;
  ifft8_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  end
  always @(negedge clk) begin
    beat_t got, exp;
    if (!rst && out_valid) begin
      checks++;
      if (in_ready) begin
        errors++;
        $display("FAIL in_ready_during_out: in_ready=%0b required 0", in_ready);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 idx=%0d with no expected beat", out_idx);
      end else if (out_ready) begin
        exp = sb.pop_front();
        got = '{out_re, out_im, out_idx, out_last};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL beat: got re=%0d im=%0d idx=%0d last=%0b required re=%0d im=%0d idx=%0d last=%0b",
                   $signed(got.re), $signed(got.im), got.idx, got.last,
                   $signed(exp.re), $signed(exp.im), exp.idx, exp.last);
        end
      end
    end
    if (out_valid && !prev_v) first_v = cyc;
    prev_v = out_valid;
  end
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask
  function automatic longint rnd(input longint p);
    return (p + 64'sd8192) >>> 14;
  endfunction
  // Reference: textbook DIT inverse FFT with a complex twiddle table in Q14
  task automatic model_push(input logic [31:0] br [8], input logic [31:0] bi [8]);
    longint xr [8], xi [8], pr, pim, ar, ai;
    longint wr [4] = '{16384, 11585, 0, -11585};
    longint wi [4] = '{0, 11585, 16384, 11585};
    for (int k = 0; k < 8; k++) begin
      int r;
      r = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
      xr[r] = longint'($signed(br[k]));
      xi[r] = longint'($signed(bi[k]));
    end
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 4; j++) begin
        int h, a, b, t;
        h = 1 << s;
        a = (j / h) * 2 * h + j % h;
        b = a + h;
        t = (j % h) * (4 >> s);
        pr = rnd(wr[t] * xr[b]) - rnd(wi[t] * xi[b]);
        pim = rnd(wr[t] * xi[b]) + rnd(wi[t] * xr[b]);
        ar = xr[a];
        ai = xi[a];
        xr[a] = ar + pr;
        xi[a] = ai + pim;
        xr[b] = ar - pr;
        xi[b] = ai - pim;
      end
    end
    for (int n = 0; n < 8; n++) sb.push_back('{32'(xr[n] >>> 3), 32'(xi[n] >>> 3), 3'(n), n == 7});
  endtask
  task automatic push_const(input int er [8], input int ei [8]);
    for (int n = 0; n < 8; n++) sb.push_back('{32'(er[n]), 32'(ei[n]), 3'(n), n == 7});
  endtask
  task automatic send_frame(input logic [31:0] br [8], input logic [31:0] bi [8], input bit gaps);
    int k = 0, c = 0;
    while (k < 8 && c < 300) begin
      @(posedge clk);
      #1;
      in_valid = !gaps || (c % 2 == 1);
      in_re = br[k];
      in_im = bi[k];
      @(negedge clk);
      if (in_valid && in_ready) begin
        k++;
        last_hs = cyc;
      end
      c++;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    if (k < 8) chk("send_timeout_beats", k, 8);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
    chk("drain_outstanding", sb.size(), 0);
  endtask
  initial begin
    logic [31:0] br [8], bi [8];
    int er [8], ei [8];
    rst = 1; in_valid = 0; in_re = 0; in_im = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("load_in_ready", in_ready, 1);
    // impulse in bin 0 -> flat time signal
    for (int i = 0; i < 8; i++) begin br[i] = 0; bi[i] = 0; er[i] = 1; ei[i] = 0; end
    br[0] = 8;
    push_const(er, ei);
    send_frame(br, bi, 0);
    drain();
    // flat spectrum -> impulse, with latency check
    for (int i = 0; i < 8; i++) begin br[i] = 100; er[i] = 0; end
    er[0] = 100;
    push_const(er, ei);
    send_frame(br, bi, 0);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    #1;
    chk("first_valid_latency", first_v - last_hs, 13);
    drain();
    // bin 4 with in_valid gaps -> alternating samples
    for (int i = 0; i < 8; i++) begin br[i] = 0; er[i] = (i % 2 == 0) ? 10 : -10; end
    br[4] = 80;
    push_const(er, ei);
    send_frame(br, bi, 1);
    drain();
    // bin 2 with output backpressure at idx 3
    for (int i = 0; i < 8; i++) br[i] = 0;
    br[2] = 800;
    er = '{100, 0, -100, 0, 100, 0, -100, 0};
    ei = '{0, 100, 0, -100, 0, 100, 0, -100};
    push_const(er, ei);
    send_frame(br, bi, 0);
    for (int i = 0; i < 60 && !(out_valid && out_idx == 3'd2); i++) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_idx", out_idx, 3);
      chk("bp_out_re", out_re, 0);
      chk("bp_out_im", out_im, -100);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    for (int i = 0; i < 40 && !(out_valid && out_last); i++) @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_last", in_ready, 1);
    drain();
    // reset during compute cycle 6 discards the frame
    for (int i = 0; i < 8; i++) begin br[i] = $urandom(); bi[i] = $urandom(); end
    send_frame(br, bi, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 8; i++) begin br[i] = 100; bi[i] = 0; er[i] = 0; ei[i] = 0; end
    er[0] = 100;
    push_const(er, ei);
    send_frame(br, bi, 0);
    drain();
    // random frames, back to back, random output backpressure
    bp_rand = 1;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 8; i++) begin
        br[i] = (f % 2 == 0) ? $urandom() : 32'($signed($urandom_range(0, 4000)) - 2000);
        bi[i] = (f % 2 == 0) ? $urandom() : 32'($signed($urandom_range(0, 4000)) - 2000);
      end
      model_push(br, bi);
      send_frame(br, bi, f % 3 == 2);
    end
    bp_rand = 0;
    out_ready = 1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
